// File: rtl/ham_pkg.sv
// Shared types and constants for the pairwise Hamming-distance sweep controller.
// Optional build macro HAM_PAIR_IDX_EN is consumed by ham_sweep_ctrl.
package ham_pkg;

    localparam int DIST_W = 5;
    localparam logic [DIST_W-1:0] MIN_INIT = 5'd16;
    localparam logic [DIST_W-1:0] MAX_INIT = 5'd0;

    typedef enum logic [3:0] {
        IDLE,
        FJH,
        FJL,
        FKH,
        FKL,
        CMP,
        WMIN,
        WMAX,
        WIJ,
        WIK,
        DONE
    } state_t;

endpackage

// File: rtl/ham_sweep_ctrl_if.sv
// Control and byte-wide data-memory bus of the Hamming sweep controller.
interface ham_sweep_ctrl_if
    import ham_pkg::*;
#(
    parameter int AW = 8
);
    // start is a level sampled only in IDLE/DONE and ignored while busy; done
    // stays high until the next accepted start; mem_rd_data returns the byte at
    // the previous cycle's mem_addr; mem_wr_en is a single-cycle byte strobe.
    logic          start;
    logic          done;
    logic          busy;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_rd_data;
    logic          mem_wr_en;
    logic [7:0]    mem_wr_data;
    state_t        dbg_state;

    modport master (
        input  start, mem_rd_data,
        output done, busy, mem_addr, mem_wr_en, mem_wr_data, dbg_state
    );

    modport slave (
        output start, mem_rd_data,
        input  done, busy, mem_addr, mem_wr_en, mem_wr_data, dbg_state
    );

endinterface

// File: rtl/ham_popcount16.sv
// Combinational population count of a 16-bit word.
module ham_popcount16
    import ham_pkg::*;
(
    input  logic [15:0]       i_word,
    output logic [DIST_W-1:0] o_count
);

    always_comb begin
        o_count = '0;
        for (int i = 0; i < 16; i++) begin
            o_count = o_count + DIST_W'(i_word[i]);
        end
    end

endmodule

// File: rtl/ham_sweep_ctrl.sv
// Sweeps all word pairs j<k, tracks min/max Hamming distance, writes results.
// Define HAM_PAIR_IDX_EN to also write the first min-distance pair indices.
module ham_sweep_ctrl
    import ham_pkg::*;
#(
    parameter int NUM_WORDS = 32,
    parameter int BASE_ADDR = 0,
    parameter int MIN_ADDR  = 64,
    parameter int MAX_ADDR  = 65,
    parameter int AW        = 8
) (
    input logic              clk,
    input logic              reset,
    ham_sweep_ctrl_if.master bus
);

    localparam int IW = $clog2(NUM_WORDS);
    localparam logic [IW-1:0] ONE    = IW'(1);
    localparam logic [IW-1:0] TWO    = IW'(2);
    localparam logic [IW-1:0] LAST_K = IW'(NUM_WORDS - 1);
    localparam logic [IW-1:0] LAST_J = IW'(NUM_WORDS - 2);

    state_t            r_state;
    logic [IW-1:0]     r_j, r_k;
    logic [DIST_W-1:0] r_min, r_max;
    logic [7:0]        r_jhi, r_jlo, r_khi;
    logic              r_jlo_pend;
    logic [AW-1:0]     r_addr;
    logic              r_wr_en;
    logic [7:0]        r_wr_data;
    logic              r_done, r_busy;
`ifdef HAM_PAIR_IDX_EN
    logic [IW-1:0]     r_min_j, r_min_k;
`endif

    logic [15:0]       w_xor;
    logic [DIST_W-1:0] w_dist, w_min_nxt, w_max_nxt;
    logic              w_lt, w_gt;

    function automatic logic [AW-1:0] byte_addr(input logic [IW-1:0] idx, input logic lo);
        return AW'(BASE_ADDR) + AW'({idx, lo});
    endfunction

    // The k low byte is not registered: it arrives on mem_rd_data during CMP.
    assign w_xor = {r_jhi, r_jlo} ^ {r_khi, bus.mem_rd_data};

    ham_popcount16 u_popcount (
        .i_word  (w_xor),
        .o_count (w_dist)
    );

    assign w_lt      = (w_dist < r_min);
    assign w_gt      = (w_dist > r_max);
    assign w_min_nxt = w_lt ? w_dist : r_min;
    assign w_max_nxt = w_gt ? w_dist : r_max;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_j        <= '0;
            r_k        <= ONE;
            r_min      <= MIN_INIT;
            r_max      <= MAX_INIT;
            r_jhi      <= '0;
            r_jlo      <= '0;
            r_khi      <= '0;
            r_jlo_pend <= 1'b0;
            r_addr     <= '0;
            r_wr_en    <= 1'b0;
            r_wr_data  <= '0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
`ifdef HAM_PAIR_IDX_EN
            r_min_j    <= '0;
            r_min_k    <= '0;
`endif
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        r_j     <= '0;
                        r_k     <= ONE;
                        r_min   <= MIN_INIT;
                        r_max   <= MAX_INIT;
                        r_addr  <= byte_addr('0, 1'b0);
                        r_done  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= FJH;
                    end
                end
                FJH: begin
                    r_addr  <= byte_addr(r_j, 1'b1);
                    r_state <= FJL;
                end
                FJL: begin
                    r_jhi      <= bus.mem_rd_data;
                    r_jlo_pend <= 1'b1;
                    r_addr     <= byte_addr(r_k, 1'b0);
                    r_state    <= FKH;
                end
                FKH: begin
                    // Only the first k after a fresh j sees the j low byte here.
                    if (r_jlo_pend) begin
                        r_jlo <= bus.mem_rd_data;
                    end
                    r_jlo_pend <= 1'b0;
                    r_addr     <= byte_addr(r_k, 1'b1);
                    r_state    <= FKL;
                end
                FKL: begin
                    r_khi   <= bus.mem_rd_data;
                    r_state <= CMP;
                end
                CMP: begin
                    r_min <= w_min_nxt;
                    r_max <= w_max_nxt;
`ifdef HAM_PAIR_IDX_EN
                    if (w_lt) begin
                        r_min_j <= r_j;
                        r_min_k <= r_k;
                    end
`endif
                    if (r_k < LAST_K) begin
                        r_k     <= r_k + ONE;
                        r_addr  <= byte_addr(r_k + ONE, 1'b0);
                        r_state <= FKH;
                    end else if (r_j < LAST_J) begin
                        r_j     <= r_j + ONE;
                        r_k     <= r_j + TWO;
                        r_addr  <= byte_addr(r_j + ONE, 1'b0);
                        r_state <= FJH;
                    end else begin
                        r_addr    <= AW'(MIN_ADDR);
                        r_wr_en   <= 1'b1;
                        r_wr_data <= 8'(w_min_nxt);
                        r_state   <= WMIN;
                    end
                end
                WMIN: begin
                    r_addr    <= AW'(MAX_ADDR);
                    r_wr_en   <= 1'b1;
                    r_wr_data <= 8'(r_max);
                    r_state   <= WMAX;
                end
`ifdef HAM_PAIR_IDX_EN
                WMAX: begin
                    r_addr    <= AW'(MIN_ADDR + 2);
                    r_wr_en   <= 1'b1;
                    r_wr_data <= 8'(r_min_j);
                    r_state   <= WIJ;
                end
                WIJ: begin
                    r_addr    <= AW'(MIN_ADDR + 3);
                    r_wr_en   <= 1'b1;
                    r_wr_data <= 8'(r_min_k);
                    r_state   <= WIK;
                end
                WIK: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= DONE;
                end
`else
                WMAX: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= DONE;
                end
`endif
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.done        = r_done;
    assign bus.busy        = r_busy;
    assign bus.mem_addr    = r_addr;
    assign bus.mem_wr_en   = r_wr_en;
    assign bus.mem_wr_data = r_wr_data;
    assign bus.dbg_state   = r_state;

endmodule
